// File: rtl/expr_pkg.sv
// Shared constants for the expression-result unpacker: the 18-field map of the
// 90-bit packed result vector, the FSM state encoding and the signature step.
package expr_pkg;

  localparam int NUM_FIELDS = 18;
  localparam int PACKED_W   = 90;
  localparam int IDX_W      = 5;
  localparam int SIG_MAX_W  = 64;

  // Widths repeat 4/5/6; fields 3..5 of every group of six are two's complement.
  localparam int unsigned FIELD_W [NUM_FIELDS] = '{
    4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6
  };
  localparam int unsigned FIELD_LSB [NUM_FIELDS] = '{
    86, 81, 75, 71, 66, 60, 56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0
  };
  localparam bit FIELD_SIGNED [NUM_FIELDS] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Rotate the low w bits of sig left by one, then XOR in data.
  function automatic logic [SIG_MAX_W-1:0] rotl_xor(input logic [SIG_MAX_W-1:0] sig,
                                                    input int unsigned          w,
                                                    input logic [SIG_MAX_W-1:0] data);
    logic [SIG_MAX_W-1:0] mask;
    mask = (SIG_MAX_W'(1) << w) - SIG_MAX_W'(1);
    return (((sig << 1) | (sig >> (w - 1))) & mask) ^ data;
  endfunction

endpackage

// File: rtl/expr_result_unpacker_if.sv
// Bus bundle between the expression block (master) and the result unpacker (slave).
interface expr_result_unpacker_if
  import expr_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int SIG_W = 32
);

  logic                in_valid;
  logic                in_ready;
  logic [PACKED_W-1:0] in_y;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_W-1:0]    out_idx;
  logic [OUT_W-1:0]    out_data;
  logic                out_last;
  logic                sig_valid;
  logic [SIG_W-1:0]    sig;
  logic                busy;

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_idx, out_data, out_last, sig_valid, sig, busy
  );

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_idx, out_data, out_last, sig_valid, sig, busy
  );

endinterface

// File: rtl/expr_field_extract.sv
// Combinational field selector: picks field idx out of the packed vector and
// sign- or zero-extends it to OUT_W bits using the constant field tables.
module expr_field_extract
  import expr_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [PACKED_W-1:0] cap,
  input  logic [IDX_W-1:0]    idx,
  output logic [OUT_W-1:0]    data
);

  int unsigned      lsb;
  int unsigned      w;
  logic             sgn;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] field;

  always_comb begin
    // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
    lsb = FIELD_LSB[0];
    w   = FIELD_W[0];
    sgn = FIELD_SIGNED[0];
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx == IDX_W'(i)) begin
        lsb = FIELD_LSB[i];
        w   = FIELD_W[i];
        sgn = FIELD_SIGNED[i];
      end
    end
    mask  = (OUT_W'(1) << w) - OUT_W'(1);
    field = OUT_W'(cap >> lsb) & mask;
    // The field's top bit is the single mask bit not covered by mask >> 1.
    if (sgn && |(field & mask & ~(mask >> 1))) field = field | ~mask;
  end

  assign data = field;

endmodule

// File: rtl/expr_result_unpacker.sv
// Receive end of the expression-block result bus: captures one packed vector,
// streams its 18 extended fields with their index and folds them into a signature.
module expr_result_unpacker
  import expr_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int SIG_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  expr_result_unpacker_if.slave  bus
);

  localparam logic [1:0]       IDLE     = ST_IDLE;
  localparam logic [1:0]       SHIFT    = ST_SHIFT;
  localparam logic [1:0]       DONE     = ST_DONE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  logic [1:0]          state_q, state_d;
  logic [PACKED_W-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic                last_q, last_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [OUT_W-1:0]    ext_data;

  // Extracting from next-state capture/index registers the beat the cycle it is shown.
  expr_field_extract #(.OUT_W(OUT_W)) u_extract (
    .cap  (cap_d),
    .idx  (idx_d),
    .data (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_d   = bus.in_y;
          idx_d   = '0;
          sig_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.out_ready) begin
          sig_d = SIG_W'(rotl_xor(SIG_MAX_W'(sig_q), SIG_W, SIG_MAX_W'(data_q)));
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    data_d = ext_data;
    last_d = (state_d == SHIFT) && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sig_q   <= sig_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SHIFT);
  assign bus.out_idx   = idx_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.sig_valid = (state_q == DONE);
  assign bus.sig       = sig_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed bench for expr_result_unpacker: hand-computed beats and signatures,
// backpressure, back-to-back vectors and reset in the middle of a stream.
module tb_expr_result_unpacker;
  import expr_pkg::*;

  typedef logic [7:0] beats_t [NUM_FIELDS];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  expr_result_unpacker_if #(.OUT_W(8), .SIG_W(32)) bus ();

  expr_result_unpacker #(.OUT_W(8), .SIG_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_vector(input string tag, input logic [89:0] y, input beats_t exp,
                            input int stall_idx, input int stall_len,
                            input logic [31:0] stall_sig, input logic [31:0] exp_sig,
                            input bit hold, input logic [89:0] next_y);
    int cyc;
    int beat;
    int left;
    int n;
    bus.in_valid = 1'b1;
    bus.in_y     = y;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, 64'(bus.in_ready), 64'd1);
    cyc  = 1;
    left = stall_len;
    @(negedge clk);
    cyc++;
    if (hold) bus.in_y = next_y;
    else      bus.in_valid = 1'b0;
    beat = 0;
    while (beat < NUM_FIELDS && cyc < 80) begin
      check($sformatf("%s valid b%0d", tag, beat), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s in_ready b%0d", tag, beat), 64'(bus.in_ready), 64'd0);
      check($sformatf("%s idx b%0d", tag, beat), 64'(bus.out_idx), 64'(beat));
      check($sformatf("%s data b%0d", tag, beat), 64'(bus.out_data), 64'(exp[beat]));
      check($sformatf("%s last b%0d", tag, beat), 64'(bus.out_last), 64'(beat == 17));
      if (beat == stall_idx && left > 0) begin
        check($sformatf("%s stall sig", tag), 64'(bus.sig), 64'(stall_sig));
        bus.out_ready = 1'b0;
        left--;
      end else begin
        bus.out_ready = 1'b1;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " beat count"}, 64'(beat), 64'd18);
    check({tag, " sig_valid"}, 64'(bus.sig_valid), 64'd1);
    check({tag, " done cycle"}, 64'(cyc), 64'(20 + stall_len));
    check({tag, " sig"}, 64'(bus.sig), 64'(exp_sig));
    check({tag, " done out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " done in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " done busy"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({tag, " pulse width"}, 64'(bus.sig_valid), 64'd0);
    check({tag, " idle in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    check({tag, " sig hold"}, 64'(bus.sig), 64'(exp_sig));
  endtask

  initial begin
    logic [89:0] v_zero, v_y3, v_mix, v_tail, v_y0;
    beats_t      e_zero, e_y3, e_mix, e_tail, e_y0;
    int          n;

    v_zero = '0;
    v_y3 = '0;   v_y3[74:71] = 4'b1000;
    v_mix = '0;  v_mix[89:86] = 4'hF;  v_mix[65:60] = 6'h20;  v_mix[55:51] = 5'h1F;
    v_tail = '0; v_tail[10:6] = 5'h10; v_tail[5:0] = 6'h20;
    v_y0 = '0;   v_y0[89:86] = 4'hF;
    e_zero = '{default: 8'h00};
    e_y3 = '{default: 8'h00};   e_y3[3] = 8'hF8;
    e_mix = '{default: 8'h00};  e_mix[0] = 8'h0F; e_mix[5] = 8'hE0; e_mix[7] = 8'h1F;
    e_tail = '{default: 8'h00}; e_tail[16] = 8'hF0; e_tail[17] = 8'hE0;
    e_y0 = '{default: 8'h00};   e_y0[0] = 8'h0F;

    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_idx", 64'(bus.out_idx), 64'd0);
    check("reset out_data", 64'(bus.out_data), 64'd0);
    check("reset out_last", 64'(bus.out_last), 64'd0);
    check("reset sig_valid", 64'(bus.sig_valid), 64'd0);
    check("reset sig", 64'(bus.sig), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_vector("zero", v_zero, e_zero, -1, 0, 32'h0, 32'h0000_0000, 1'b0, '0);
    run_vector("y3", v_y3, e_y3, -1, 0, 32'h0, 32'h003E_0000, 1'b0, '0);
    run_vector("mix", v_mix, e_mix, -1, 0, 32'h0, 32'h0010_7C00, 1'b0, '0);
    run_vector("mix_stall", v_mix, e_mix, 7, 3, 32'h0000_0200, 32'h0010_7C00, 1'b0, '0);
    run_vector("tail", v_tail, e_tail, -1, 0, 32'h0, 32'h0000_0100, 1'b0, '0);

    // Second vector offered with in_valid held through the first vector's stream.
    run_vector("b2b_a", v_y3, e_y3, -1, 0, 32'h0, 32'h003E_0000, 1'b1, v_y0);
    run_vector("b2b_b", v_y0, e_y0, -1, 0, 32'h0, 32'h001E_0000, 1'b0, '0);

    bus.in_valid = 1'b1;
    bus.in_y     = v_mix;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_idx != 5'd10 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst reach idx10", 64'(bus.out_idx), 64'd10);
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst sig", 64'(bus.sig), 64'd0);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst sig_valid", 64'(bus.sig_valid), 64'd0);
    check("midrst out_idx", 64'(bus.out_idx), 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("midrst held sig_valid", 64'(bus.sig_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post rst sig_valid", 64'(bus.sig_valid), 64'd0);
    run_vector("post_rst", v_y3, e_y3, -1, 0, 32'h0, 32'h003E_0000, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
